// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared state encoding and default width for the counter sequencer
package counter_seq_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
`ifdef COUNTER_SEQ_PAUSE_EN
    , PAUSE
`endif
  } seq_state_t;
endpackage

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: run-request and status bundle; pause exists only with COUNTER_SEQ_PAUSE_EN
interface counter_sequencer_if
  import counter_seq_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH);
  logic start, start_ready, periodic, stop, busy, tick, done;
  logic [WIDTH-1:0] period, count;
`ifdef COUNTER_SEQ_PAUSE_EN
  logic pause;
  modport master (output start, period, periodic, stop, pause, input start_ready, count, busy, tick, done);
  modport slave (input start, period, periodic, stop, pause, output start_ready, count, busy, tick, done);
`else
  modport master (output start, period, periodic, stop, input start_ready, count, busy, tick, done);
  modport slave (input start, period, periodic, stop, output start_ready, count, busy, tick, done);
`endif
endinterface

// File: rtl/counter_sequencer_cnt_datapath.sv
// cnt_datapath: WIDTH-bit up-counter register with synchronous clear and enable
module cnt_datapath #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= q + 1'b1;
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: one-shot/periodic run control for the up-counter.
// Define COUNTER_SEQ_PAUSE_EN to add the pause input and PAUSE state.
module counter_sequencer
  import counter_seq_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH) (
  input logic clk,
  input logic rst,
  counter_sequencer_if.slave bus
);
  seq_state_t state;
  logic [WIDTH-1:0] period_r, count;
  logic mode_r, pz, match, live, clr, en;
`ifdef COUNTER_SEQ_PAUSE_EN
  assign pz = bus.pause;
`else
  assign pz = 1'b0;
`endif
  assign match = count == period_r;
  // a RUN cycle that neither stops nor pauses is the only one that may tick or count
  assign live = state == RUN && !bus.stop && !pz;
  assign clr = (state == IDLE && bus.start) || (live && match && mode_r);
  assign en = live && !match;
  cnt_datapath #(.WIDTH(WIDTH)) u_cnt (.clk(clk), .rst(rst), .clr(clr), .en(en), .q(count));
  assign bus.count = count;
  assign bus.start_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.tick = live && match;
  assign bus.done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      period_r <= '0;
      mode_r <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          period_r <= bus.period;
          mode_r <= bus.periodic;
        end
        RUN:
          if (bus.stop) state <= DONE;
`ifdef COUNTER_SEQ_PAUSE_EN
          else if (pz) state <= PAUSE;
`endif
          else if (match && !mode_r) state <= DONE;
`ifdef COUNTER_SEQ_PAUSE_EN
        PAUSE: state <= bus.stop ? DONE : pz ? PAUSE : RUN;
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: random and directed stimulus checked against a run-level model
module tb_counter_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  counter_sequencer_if #(.WIDTH(8)) bus ();
  counter_sequencer #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0, bad = 0;
  // model: phase 0 idle, 1 running, 2 paused, 3 finishing; e = elapsed counting cycles of the run
  int ph = 0, e = 0, mp = 0, hold = 0;
  bit mm = 1'b0;
  logic [7:0] oc;
  logic ot, od, ob, orr, pzv;
  int e1[6] = '{0, 8, 16, 28, 26, 25};
`ifdef COUNTER_SEQ_PAUSE_EN
  assign pzv = bus.pause;
`else
  assign pzv = 1'b0;
`endif

  task automatic lit(input string n, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, act, req);
    end
  endtask

  task automatic cyc();
    int ec;
    logic et;
    @(negedge clk);
    oc = bus.count; ot = bus.tick; od = bus.done; ob = bus.busy; orr = bus.start_ready;
    if (rst) begin
      ph = 0; e = 0; mp = 0; mm = 1'b0; hold = 0;
    end
    ec = (ph == 1 || ph == 2) ? (mm ? e % (mp + 1) : e) : hold;
    et = ph == 1 && !bus.stop && !pzv && ec == mp;
    total++;
    if ({oc, ot, od, ob, orr} !== {ec[7:0], et, ph == 3, ph != 0, ph == 0}) begin
      bad++;
      $display("FAIL model t=%0t got count=%0d tick=%b done=%b busy=%b ready=%b want count=%0d tick=%b done=%b busy=%b ready=%b",
               $time, oc, ot, od, ob, orr, ec, et, ph == 3, ph != 0, ph == 0);
    end
    if (!rst)
      case (ph)
        0: if (bus.start) begin ph = 1; e = 0; mp = int'(bus.period); mm = bus.periodic; end
        1: if (bus.stop) begin hold = ec; ph = 3; end
           else if (pzv) ph = 2;
           else if (et && !mm) begin hold = ec; ph = 3; end
           else e++;
        2: if (bus.stop) begin hold = ec; ph = 3; end
           else if (!pzv) ph = 1;
        default: ph = 0;
      endcase
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int p, input bit m);
    bus.period = 8'(p); bus.periodic = m; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  initial begin
    int nt, nb, sc;
    bus.start = 1'b0; bus.period = '0; bus.periodic = 1'b0; bus.stop = 1'b0;
`ifdef COUNTER_SEQ_PAUSE_EN
    bus.pause = 1'b0;
`endif
    repeat (2) cyc();
    lit("reset_count", int'(oc), 0);
    lit("reset_ready", int'(orr), 1);
    rst = 1'b0;
    go(3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      lit($sformatf("oneshot_step%0d", i), int'({oc, ot, od, orr}), e1[i]);
    end
    go(2, 1'b1);
    nt = 0; nb = 0;
    repeat (10) begin cyc(); nt += int'(ot); nb += int'(ob); end
    lit("periodic_ticks", nt, 3);
    lit("periodic_busy", nb, 10);
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    repeat (2) cyc();
    go(0, 1'b1);
    nt = 0; sc = 0;
    repeat (5) begin cyc(); nt += int'(ot); sc += int'(oc); end
    lit("p0_ticks", nt, 5);
    lit("p0_countsum", sc, 0);
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    cyc(); lit("p0_stop_done", int'(od), 1);
    cyc(); lit("p0_stop_ready", int'(orr), 1);
    go(4, 1'b0);
    repeat (4) cyc();
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    lit("stopmatch_tick", int'(ot), 0);
    lit("stopmatch_count", int'(oc), 4);
    cyc();
    lit("stopmatch_done", int'(od), 1);
    lit("stopmatch_hold", int'(oc), 4);
    cyc();
    go(6, 1'b0);
    repeat (2) cyc();
    bus.start = 1'b1; bus.period = 8'd1; cyc(); bus.start = 1'b0; bus.period = '0;
    repeat (3) cyc();
    cyc();
    lit("ignored_start_tick", int'({oc, ot}), 13);
    repeat (2) cyc();
    go(9, 1'b0);
    repeat (3) cyc();
    #2 rst = 1'b1;
    #1;
    lit("midrun_rst_count", int'(bus.count), 0);
    lit("midrun_rst_ready", int'(bus.start_ready), 1);
    cyc();
    rst = 1'b0;
`ifdef COUNTER_SEQ_PAUSE_EN
    go(5, 1'b0);
    repeat (2) cyc();
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin cyc(); lit("pause_hold", int'(oc), 2); end
    bus.pause = 1'b0;
    nt = -1;
    for (int i = 0; i < 8; i++) begin cyc(); if (ot && nt < 0) nt = i; end
    lit("pause_tick_index", nt, 4);
`endif
    for (int i = 0; i < 600; i++) begin
      bus.start = $urandom_range(0, 3) == 0;
      bus.period = 8'($urandom_range(0, 6));
      bus.periodic = 1'($urandom_range(0, 1));
      bus.stop = $urandom_range(0, 15) == 0;
`ifdef COUNTER_SEQ_PAUSE_EN
      bus.pause = $urandom_range(0, 5) == 0;
`endif
      cyc();
    end
    bus.start = 1'b0; bus.stop = 1'b1;
`ifdef COUNTER_SEQ_PAUSE_EN
    bus.pause = 1'b0;
`endif
    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
